mas_mul_arbiter: RTL and testbench
==================================

# mas_mul_arbiter

Round-robin arbiter that shares one `mas_mul_radix_top` multiplier between `NREQ` requesters. Each requester issues 32x32 unsigned multiply requests over a valid/ready handshake. The block drives the multiplier operands, tracks each in-flight operation by requester tag through a fixed-latency pipeline, and returns the 64-bit product to the owning requester over a held valid/ready response. It sits between the client blocks and the multiplier instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `MUL_LAT`, 2: number of clock edges after operand registration at which `mul_res` holds the product (≥1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle, one-hot or zero.
- `req_a`  in  NREQ*32  operand A; requester i at bits [32i+31:32i].
- `req_b`  in  NREQ*32  operand B; same packing.
- `rsp_valid`  out  NREQ  result valid per requester.
- `rsp_ready`  in  NREQ  result consumed per requester.
- `rsp_data`  out  NREQ*64  result per requester; requester i at bits [64i+63:64i].
- `mul_in1`  out  32  multiplier operand 1, registered.
- `mul_in2`  out  32  multiplier operand 2, registered.
- `mul_res`  in  64  multiplier product.

## Operation
- State: `busy[NREQ]`, round-robin pointer `ptr` (0..NREQ-1), tag pipeline of depth `MUL_LAT` (valid + tag per stage), per-requester result registers.
- Eligibility: requester i is eligible when `req_valid[i] && !busy[i]`.
- Grant: the first eligible index searching `ptr, ptr+1, …` modulo NREQ. `req_ready[grant]=1`; all other bits are 0. `req_ready` is combinational from `req_valid`/`busy`/`ptr`.
- Accept (handshake at edge E0):
  - `mul_in1<=req_a[g]`, `mul_in2<=req_b[g]`.
  - Pipeline stage 0 `<= {1,g}`.
  - `busy[g]<=1`.
  - `ptr<=(g+1) mod NREQ`.
- No accept: `ptr` unchanged. `mul_in1`/`mul_in2` hold their last values. Stage 0 valid `<=0`.
- Pipeline advances every cycle. When the tail stage is valid at edge E0+MUL_LAT, `mul_res` is sampled into `rsp_data[tag]` and `rsp_valid[tag]<=1`.
- Response: `rsp_valid[i]` and `rsp_data[i]` are held stable until `rsp_valid[i]&&rsp_ready[i]`. At that edge, `rsp_valid[i]<=0` and `busy[i]<=0`. `rsp_data[i]` keeps its value.
- Each requester has at most one operation outstanding, so a result slot is never overwritten. Up to NREQ operations can be in flight at once. Issue throughput is one per cycle.
- Arithmetic: unsigned 32x32→64, computed by the multiplier. The block passes `mul_res` through unmodified.

## Timing
- Reset (asynchronous assert, any cycle): `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `mul_in1`=`mul_in2`=0, `busy`=0, `ptr`=0, all pipeline valids 0.
- Reset mid-operation: in-flight operations are discarded and no response is produced for them. After reset deassert, the first accept can occur at the first rising edge.
- Latency: accept at edge E0 → `rsp_valid[g]` high after edge E0+MUL_LAT. This is 2 cycles with the default.
- Same-cycle response handshake and new request from the same requester: the request is not accepted, because `busy` is still set. It is accepted no earlier than the next edge.
- `rsp_ready[i]` asserted while `rsp_valid[i]`=0: ignored.
- `ptr` wrap: after a grant to NREQ-1, `ptr`=0.
- A requester dropping `req_valid` before handshake is allowed. No state changes.

## Test plan
- Reset: hold `rstn`=0 with all `req_valid` set → every output is 0. Release → the first edge accepts requester 0.
- Single op: requester 0, a=0x0000000F, b=0x0000000F, accepted at E0 → `rsp_valid[0]`=1 after E0+2, `rsp_data[0]`=0x00000000000000E1, held until `rsp_ready[0]`.
- Max operands: a=b=0xFFFFFFFF → `rsp_data`=0xFFFFFFFE00000001.
- Fairness: all 4 requesters valid at once with a=i+1, b=0x10 → grants 0,1,2,3 on consecutive edges. Responses 0x10,0x20,0x30,0x40 arrive on consecutive cycles starting 2 cycles after the first grant. A second round after all are consumed also grants 0→3, since `ptr`=0.
- Backpressure: hold `rsp_ready[1]`=0 → `rsp_valid[1]`/`rsp_data[1]` stay stable, and `req_ready[1]` stays 0 while requester 1 requests again. Other requesters keep being served. Assert `rsp_ready[1]` → requester 1 is accepted on the following edge.
- Reset mid-flight: assert `rstn`=0 one cycle after accepting 2 ops → no `rsp_valid` ever rises for them, and all outputs return to 0 immediately.

Source files
------------

// File: rtl/mas_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mas_mul_arbiter
// Description : Round-robin arbiter sharing one fixed-latency 32x32 unsigned
//               multiplier between NREQ requesters. Requests are taken over a
//               valid/ready handshake. Each in-flight operation carries the
//               requester tag down a MUL_LAT-deep pipeline, and the 64-bit
//               product is returned on a held valid/ready response.
// Ports       : clk, rstn           - clock, asynchronous active-low reset
//               req_valid/req_ready - per-requester request handshake
//               req_a/req_b         - packed operands, 32 bits per requester
//               rsp_valid/rsp_ready - per-requester response handshake
//               rsp_data            - packed results, 64 bits per requester
//               mul_in1/mul_in2     - registered multiplier operands
//               mul_res             - multiplier product input
// Parameters  : NREQ (2..8) requesters, MUL_LAT (>=1) multiplier latency
// Revision    : 1.0 - initial release
// ============================================================================
module mas_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*64-1:0]   rsp_data,
  output logic [31:0]          mul_in1,
  output logic [31:0]          mul_in2,
  input  logic [63:0]          mul_res
);

  localparam int c_pw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_pw-1:0] c_last = c_pw'(NREQ - 1);

  logic [NREQ-1:0]  r_busy;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [63:0]      r_rsp_data [NREQ];
  logic [c_pw-1:0]  r_ptr;
  logic [31:0]      r_mul_in1;
  logic [31:0]      r_mul_in2;
  logic [MUL_LAT-1:0] r_pv;
  logic [c_pw-1:0]  r_pt [MUL_LAT];

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_req_ready;
  logic [NREQ-1:0]  w_tail_hit;
  logic [NREQ-1:0]  w_rsp_done;
  logic [c_pw-1:0]  w_grant;
  logic [c_pw-1:0]  w_cand;
  logic [c_pw-1:0]  w_ptr_nxt;
  logic             w_accept;
  logic [31:0]      w_op_a;
  logic [31:0]      w_op_b;
  int               w_sum;

  // Search eligible requesters starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    w_elig   = req_valid & ~r_busy;
    w_accept = 1'b0;
    w_grant  = '0;
    w_cand   = '0;
    w_sum    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= NREQ) begin
        w_sum = w_sum - NREQ;
      end
      w_cand = w_sum[c_pw-1:0];
      if (!w_accept && w_elig[w_cand]) begin
        w_accept = 1'b1;
        w_grant  = w_cand;
      end
    end
  end

  // Ready is forced low while reset is asserted so no requester sees a
  // handshake that the held-in-reset state cannot take.
  always_comb begin
    w_req_ready = '0;
    if (rstn && w_accept) begin
      w_req_ready[w_grant] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_grant == c_last) ? '0 : w_grant + 1'b1;
  assign w_op_a    = req_a[int'(w_grant)*32 +: 32];
  assign w_op_b    = req_b[int'(w_grant)*32 +: 32];

  // Tail of the tag pipeline lines up with mul_res holding the product.
  always_comb begin
    w_tail_hit = '0;
    w_rsp_done = r_rsp_valid & rsp_ready;
    for (int i = 0; i < NREQ; i++) begin
      w_tail_hit[i] = r_pv[MUL_LAT-1] && (r_pt[MUL_LAT-1] == c_pw'(i));
    end
  end

  // Operand registers, round-robin pointer and tag pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr     <= '0;
      r_mul_in1 <= '0;
      r_mul_in2 <= '0;
      r_pv      <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        r_pt[s] <= '0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pt[0] <= w_grant;
      for (int s = 1; s < MUL_LAT; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pt[s] <= r_pt[s-1];
      end
      if (w_accept) begin
        r_mul_in1 <= w_op_a;
        r_mul_in2 <= w_op_b;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  // Per-requester busy flag and response slot. A requester stays busy from
  // accept until its response is consumed, so the slot is never overwritten
  // and set/clear of the same bit can never coincide.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy      <= '0;
      r_rsp_valid <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_rsp_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept && (w_grant == c_pw'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_rsp_done[i]) begin
          r_busy[i] <= 1'b0;
        end

        if (w_tail_hit[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= mul_res;
        end else if (w_rsp_done[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign mul_in1   = r_mul_in1;
  assign mul_in2   = r_mul_in2;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp_data
      assign rsp_data[gi*64 +: 64] = r_rsp_data[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mas_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mas_mul_arbiter
// Description : Directed self-checking bench for mas_mul_arbiter with a
//               one-register behavioural multiplier (product valid one edge
//               after the operands register, sampled by the DUT one edge
//               later, matching MUL_LAT = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mas_mul_arbiter;

  localparam int NREQ = 4;

  logic               clk;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [NREQ*64-1:0] rsp_data;
  logic [31:0]        mul_in1;
  logic [31:0]        mul_in2;
  logic [63:0]        mul_res;

  int n_vec;
  int n_err;

  mas_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_res   (mul_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mul_res <= 64'(mul_in1) * 64'(mul_in2);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [63:0] rd(input int i);
    return rsp_data[i*64 +: 64];
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn      = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'h0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'h10);

    // Reset with all requests pending
    step(); step();
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 4'h0);
    chk("rst_rsp_data",  rsp_data,  256'h0);
    chk("rst_mul_in1",   mul_in1,   32'h0);
    chk("rst_mul_in2",   mul_in2,   32'h0);

    // Release: requester 0 gets the first edge
    rstn = 1'b1;
    #1 chk("rel_req_ready", req_ready, 4'b0001);

    // Round 1: grants 0,1,2,3 on consecutive edges
    step(); // after E0
    chk("r1_gnt1",   req_ready, 4'b0010);
    chk("r1_in1_0",  mul_in1,   32'h1);
    chk("r1_in2_0",  mul_in2,   32'h10);
    step(); // after E1
    chk("r1_gnt2",   req_ready, 4'b0100);
    chk("r1_in1_1",  mul_in1,   32'h2);
    chk("r1_rv_e1",  rsp_valid, 4'b0000);
    step(); // after E2
    chk("r1_gnt3",   req_ready, 4'b1000);
    chk("r1_rv_e2",  rsp_valid, 4'b0001);
    chk("r1_d0",     rd(0),     64'h10);
    step(); // after E3
    chk("r1_full",   req_ready, 4'b0000);
    chk("r1_rv_e3",  rsp_valid, 4'b0011);
    chk("r1_d1",     rd(1),     64'h20);
    step(); // after E4
    chk("r1_rv_e4",  rsp_valid, 4'b0111);
    chk("r1_d2",     rd(2),     64'h30);
    step(); // after E5
    chk("r1_rv_e5",  rsp_valid, 4'b1111);
    chk("r1_d3",     rd(3),     64'h40);
    step(); // held without rsp_ready
    chk("r1_hold_rv", rsp_valid, 4'b1111);
    chk("r1_hold_d0", rd(0),     64'h10);
    // Consume all with requests still high: busy blocks same-edge re-accept
    rsp_ready = 4'hF;
    #1 chk("r1_samecyc", req_ready, 4'b0000);
    step();
    chk("r1_consumed", rsp_valid, 4'b0000);
    chk("r2_gnt0",     req_ready, 4'b0001);

    // Round 2: single-op, max operands and misc products; ptr back at 0
    rsp_ready = 4'h0;
    set_op(0, 32'h0000000F, 32'h0000000F);
    set_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    set_op(2, 32'h12345678, 32'h00000010);
    set_op(3, 32'h00010000, 32'h00010000);
    step(); chk("r2_gnt1", req_ready, 4'b0010);
    step(); chk("r2_gnt2", req_ready, 4'b0100);
    step(); chk("r2_gnt3", req_ready, 4'b1000);
    chk("r2_d0", rd(0), 64'h00000000000000E1);
    step(); chk("r2_d1", rd(1), 64'hFFFFFFFE00000001);
    step(); chk("r2_d2", rd(2), 64'h0000000123456780);
    step(); chk("r2_d3", rd(3), 64'h0000000100000000);
    chk("r2_rv", rsp_valid, 4'b1111);

    // Backpressure on requester 1
    rsp_ready = 4'b1101;
    step();
    chk("bp_rv",     rsp_valid, 4'b0010);
    chk("bp_d1",     rd(1),     64'hFFFFFFFE00000001);
    chk("bp_gnt0",   req_ready, 4'b0001);
    rsp_ready = 4'b0000;
    set_op(0, 32'd3,     32'd5);
    set_op(2, 32'd7,     32'd9);
    set_op(3, 32'h100,   32'h100);
    step(); chk("bp_gnt2", req_ready, 4'b0100);
    req_valid[0] = 1'b0;
    step(); chk("bp_gnt3", req_ready, 4'b1000);
    req_valid[2] = 1'b0;
    step(); chk("bp_none", req_ready, 4'b0000);
    chk("bp_rv2", rsp_valid, 4'b0011);
    req_valid[3] = 1'b0;
    step();
    step();
    chk("bp_rv3", rsp_valid, 4'b1111);
    chk("bp_d0",  rd(0), 64'd15);
    chk("bp_d2",  rd(2), 64'd63);
    chk("bp_d3",  rd(3), 64'h10000);
    chk("bp_d1s", rd(1), 64'hFFFFFFFE00000001);
    rsp_ready = 4'b0010;
    #1 chk("bp_r1_blk", req_ready, 4'b0000);
    step();
    chk("bp_rv4",   rsp_valid, 4'b1101);
    chk("bp_d1kep", rd(1),     64'hFFFFFFFE00000001);
    chk("bp_gnt1",  req_ready, 4'b0010);
    rsp_ready = 4'b0000;
    set_op(1, 32'h20, 32'h3);
    step();
    chk("bp_in1", mul_in1, 32'h20);
    req_valid = 4'b0000;
    step();
    chk("bp_rv5", rsp_valid, 4'b1101);
    step();
    chk("bp_rv6", rsp_valid, 4'b1111);
    chk("bp_d1n", rd(1),     64'h60);

    // Reset mid-flight
    rsp_ready = 4'hF;
    step();
    chk("mf_clr", rsp_valid, 4'b0000);
    rsp_ready = 4'h0;
    set_op(0, 32'd2, 32'd2);
    set_op(1, 32'd3, 32'd3);
    req_valid = 4'b0011;
    step(); // accept 0
    req_valid[0] = 1'b0;
    step(); // accept 1
    chk("mf_in1", mul_in1, 32'd3);
    req_valid = 4'b0000;
    rstn = 1'b0;
    #1;
    chk("mf_req_ready", req_ready, 4'h0);
    chk("mf_rsp_valid", rsp_valid, 4'h0);
    chk("mf_rsp_data",  rsp_data,  256'h0);
    chk("mf_mul_in1",   mul_in1,   32'h0);
    chk("mf_mul_in2",   mul_in2,   32'h0);
    step(); step();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mf_no_rsp", rsp_valid, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
